// File: rtl/eu_wakeup_iqueue_pkg.sv
// Shared types and default sizes for the execution-unit wakeup instruction queue.
//
// Contents:
//   EU_LOG2_WIQUEUE_DEPTH : default log2 of the queue depth
//   EU_NUM_SRC            : default source operands per instruction
//   EU_NUM_WAKE           : default wakeup broadcast channels
//   EU_ADDR_W             : default operand/destination tag width
//   EU_OPCODE_W           : default opcode width
//   type_wiq_entry        : one queue entry at the default sizes
package eu_wakeup_iqueue_pkg;

  localparam int EU_LOG2_WIQUEUE_DEPTH = 2;
  localparam int EU_NUM_SRC            = 2;
  localparam int EU_NUM_WAKE           = 2;
  localparam int EU_ADDR_W             = 6;
  localparam int EU_OPCODE_W           = 5;

  typedef struct packed {
    logic                                 valid;
    logic [EU_OPCODE_W-1:0]               opcode;
    logic [EU_ADDR_W-1:0]                 opd;
    logic [EU_NUM_SRC-1:0][EU_ADDR_W-1:0] src;
    logic [EU_NUM_SRC-1:0]                src_rdy;
  } type_wiq_entry;

endpackage

// File: rtl/eu_wakeup_iqueue_if.sv
// Bus interface of the wakeup instruction queue: dispatch, wakeup broadcast,
// issue handshake, flush and occupancy.
//
// Modports:
//   master : the side that dispatches, broadcasts wakeups and accepts issues
//   slave  : the queue itself
interface eu_wakeup_iqueue_if #(
  parameter int LOG2_DEPTH = eu_wakeup_iqueue_pkg::EU_LOG2_WIQUEUE_DEPTH,
  parameter int NUM_SRC    = eu_wakeup_iqueue_pkg::EU_NUM_SRC,
  parameter int NUM_WAKE   = eu_wakeup_iqueue_pkg::EU_NUM_WAKE,
  parameter int ADDR_W     = eu_wakeup_iqueue_pkg::EU_ADDR_W,
  parameter int OPCODE_W   = eu_wakeup_iqueue_pkg::EU_OPCODE_W
);

  logic                         dispatch_valid_i;
  logic                         dispatch_ready_o;
  logic [OPCODE_W-1:0]          dispatch_opcode_i;
  logic [ADDR_W-1:0]            dispatch_opd_i;
  logic [NUM_SRC*ADDR_W-1:0]    dispatch_src_i;
  logic [NUM_SRC-1:0]           dispatch_src_rdy_i;

  logic [NUM_WAKE-1:0]          wake_valid_i;
  logic [NUM_WAKE*ADDR_W-1:0]   wake_addr_i;

  logic                         issue_valid_o;
  logic                         issue_ready_i;
  logic [OPCODE_W-1:0]          issue_opcode_o;
  logic [ADDR_W-1:0]            issue_opd_o;
  logic [NUM_SRC*ADDR_W-1:0]    issue_src_o;

  logic                         flush_i;
  logic [LOG2_DEPTH:0]          count_o;
  logic                         empty_o;

  modport master (
    output dispatch_valid_i, dispatch_opcode_i, dispatch_opd_i,
    output dispatch_src_i, dispatch_src_rdy_i,
    output wake_valid_i, wake_addr_i,
    output issue_ready_i, flush_i,
    input  dispatch_ready_o, issue_valid_o, issue_opcode_o,
    input  issue_opd_o, issue_src_o, count_o, empty_o
  );

  modport slave (
    input  dispatch_valid_i, dispatch_opcode_i, dispatch_opd_i,
    input  dispatch_src_i, dispatch_src_rdy_i,
    input  wake_valid_i, wake_addr_i,
    input  issue_ready_i, flush_i,
    output dispatch_ready_o, issue_valid_o, issue_opcode_o,
    output issue_opd_o, issue_src_o, count_o, empty_o
  );

endinterface

// File: rtl/eu_wakeup_match.sv
// Combinational tag comparator: checks NUM_SRC source addresses against
// NUM_WAKE wakeup broadcasts and flags every source that matches a valid
// channel on the full address width.
//
// Ports:
//   src        : source addresses, src k in [k*ADDR_W +: ADDR_W]
//   wake_valid : per-channel broadcast strobe
//   wake_addr  : per-channel broadcast address
//   hit        : per-source match flag
module eu_wakeup_match #(
  parameter int NUM_SRC  = 2,
  parameter int NUM_WAKE = 2,
  parameter int ADDR_W   = 6
) (
  input  logic [NUM_SRC*ADDR_W-1:0]  src,
  input  logic [NUM_WAKE-1:0]        wake_valid,
  input  logic [NUM_WAKE*ADDR_W-1:0] wake_addr,
  output logic [NUM_SRC-1:0]         hit
);

  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int j = 0; j < NUM_WAKE; j++) begin
        if (wake_valid[j] &&
            (wake_addr[j*ADDR_W +: ADDR_W] == src[k*ADDR_W +: ADDR_W])) begin
          hit[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eu_wakeup_iqueue.sv
// Execution-unit wakeup instruction queue. A circular buffer holds dispatched
// instructions until every source operand has been seen, then issues them
// strictly in order from the head over a valid/ready handshake.
//
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-high reset
//   q     : slave side of eu_wakeup_iqueue_if (dispatch, wakeup, issue,
//           flush, count/empty)
module eu_wakeup_iqueue
  import eu_wakeup_iqueue_pkg::*;
#(
  parameter int LOG2_DEPTH = EU_LOG2_WIQUEUE_DEPTH,
  parameter int NUM_SRC    = EU_NUM_SRC,
  parameter int NUM_WAKE   = EU_NUM_WAKE,
  parameter int ADDR_W     = EU_ADDR_W,
  parameter int OPCODE_W   = EU_OPCODE_W
) (
  input  logic             clk,
  input  logic             reset,
  eu_wakeup_iqueue_if.slave q
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;

  logic [LOG2_DEPTH-1:0]     wr_ptr;
  logic [LOG2_DEPTH-1:0]     rd_ptr;
  logic [CNT_W-1:0]          count;
  logic [DEPTH-1:0]          ent_valid;
  logic [NUM_SRC-1:0]        ent_rdy    [DEPTH];
  logic [OPCODE_W-1:0]       ent_opcode [DEPTH];
  logic [ADDR_W-1:0]         ent_opd    [DEPTH];
  logic [NUM_SRC*ADDR_W-1:0] ent_src    [DEPTH];

  logic [NUM_SRC-1:0]        ent_hit    [DEPTH];
  logic [NUM_SRC-1:0]        disp_hit;

  logic full;
  logic head_valid;
  logic do_disp;
  logic do_issue;

  // Wakeup matching: one comparator per stored entry, one for the dispatch path
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent_match
    eu_wakeup_match #(
      .NUM_SRC  (NUM_SRC),
      .NUM_WAKE (NUM_WAKE),
      .ADDR_W   (ADDR_W)
    ) u_match (
      .src        (ent_src[g]),
      .wake_valid (q.wake_valid_i),
      .wake_addr  (q.wake_addr_i),
      .hit        (ent_hit[g])
    );
  end

  eu_wakeup_match #(
    .NUM_SRC  (NUM_SRC),
    .NUM_WAKE (NUM_WAKE),
    .ADDR_W   (ADDR_W)
  ) u_disp_match (
    .src        (q.dispatch_src_i),
    .wake_valid (q.wake_valid_i),
    .wake_addr  (q.wake_addr_i),
    .hit        (disp_hit)
  );

  // Handshake decode from registered state; flush suppresses both transfers
  assign full       = (count == CNT_W'(DEPTH));
  assign head_valid = ent_valid[rd_ptr];
  assign do_disp    = q.dispatch_valid_i && !full && !q.flush_i;
  assign do_issue   = q.issue_valid_o && q.issue_ready_i && !q.flush_i;

  // Control state: pointers, occupancy, valid and ready bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) ent_rdy[i] <= '0;
    end else if (q.flush_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) ent_rdy[i] <= '0;
    end else begin
      // Ready bits only accumulate while an entry lives
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i]) ent_rdy[i] <= ent_rdy[i] | ent_hit[i];
      end
      if (do_issue) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + LOG2_DEPTH'(1);
      end
      // The write slot is never valid when dispatch is accepted, so this
      // cannot collide with the wakeup update above
      if (do_disp) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_rdy[wr_ptr]   <= q.dispatch_src_rdy_i | disp_hit;
        wr_ptr            <= wr_ptr + LOG2_DEPTH'(1);
      end
      case ({do_disp, do_issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage: written on accepted dispatch only, never reset
  always_ff @(posedge clk) begin
    if (do_disp) begin
      ent_opcode[wr_ptr] <= q.dispatch_opcode_i;
      ent_opd[wr_ptr]    <= q.dispatch_opd_i;
      ent_src[wr_ptr]    <= q.dispatch_src_i;
    end
  end

  // Outputs: purely from registered state; payload forced to zero when the
  // head slot is empty so unreset storage never reaches the pins
  assign q.dispatch_ready_o = !full;
  assign q.issue_valid_o    = head_valid && (&ent_rdy[rd_ptr]);
  assign q.issue_opcode_o   = head_valid ? ent_opcode[rd_ptr] : '0;
  assign q.issue_opd_o      = head_valid ? ent_opd[rd_ptr]    : '0;
  assign q.issue_src_o      = head_valid ? ent_src[rd_ptr]    : '0;
  assign q.count_o          = count;
  assign q.empty_o          = (count == '0);

endmodule

// File: tb/tb_eu_wakeup_iqueue.sv
module tb_eu_wakeup_iqueue;

  localparam int LOG2_DEPTH = 2;
  localparam int NUM_SRC    = 2;
  localparam int NUM_WAKE   = 2;
  localparam int ADDR_W     = 6;
  localparam int OPCODE_W   = 5;
  localparam int DEPTH      = 1 << LOG2_DEPTH;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  eu_wakeup_iqueue_if #(
    .LOG2_DEPTH (LOG2_DEPTH), .NUM_SRC (NUM_SRC), .NUM_WAKE (NUM_WAKE),
    .ADDR_W (ADDR_W), .OPCODE_W (OPCODE_W)
  ) qif ();

  eu_wakeup_iqueue #(
    .LOG2_DEPTH (LOG2_DEPTH), .NUM_SRC (NUM_SRC), .NUM_WAKE (NUM_WAKE),
    .ADDR_W (ADDR_W), .OPCODE_W (OPCODE_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .q     (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered list of live instructions, head at index 0
  typedef struct packed {
    logic [OPCODE_W-1:0]       opcode;
    logic [ADDR_W-1:0]         opd;
    logic [NUM_SRC*ADDR_W-1:0] src;
    logic [NUM_SRC-1:0]        rdy;
  } m_ent_t;

  m_ent_t mq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit woke(input logic [ADDR_W-1:0] a);
    for (int j = 0; j < NUM_WAKE; j++)
      if (qif.wake_valid_i[j] && qif.wake_addr_i[j*ADDR_W +: ADDR_W] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Compare outputs against the model, advance the model with the inputs
  // currently driven, then move to the next falling edge.
  task automatic tick();
    int     n;
    bit     exp_iv;
    bit     fire;
    bit     acc;
    m_ent_t e;
    n      = mq.size();
    exp_iv = (n > 0) && (&mq[0].rdy);
    chk("dispatch_ready", 32'(qif.dispatch_ready_o), 32'(n < DEPTH));
    chk("issue_valid", 32'(qif.issue_valid_o), 32'(exp_iv));
    chk("count", 32'(qif.count_o), 32'(n));
    chk("empty", 32'(qif.empty_o), 32'(n == 0));
    if (exp_iv) begin
      chk("issue_opcode", 32'(qif.issue_opcode_o), 32'(mq[0].opcode));
      chk("issue_opd", 32'(qif.issue_opd_o), 32'(mq[0].opd));
      chk("issue_src", 32'(qif.issue_src_o), 32'(mq[0].src));
    end
    if (qif.flush_i) begin
      mq.delete();
    end else begin
      fire = exp_iv && qif.issue_ready_i;
      acc  = qif.dispatch_valid_i && (n < DEPTH);
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        for (int k = 0; k < NUM_SRC; k++)
          if (woke(e.src[k*ADDR_W +: ADDR_W])) e.rdy[k] = 1'b1;
        mq[i] = e;
      end
      if (fire) void'(mq.pop_front());
      if (acc) begin
        e.opcode = qif.dispatch_opcode_i;
        e.opd    = qif.dispatch_opd_i;
        e.src    = qif.dispatch_src_i;
        for (int k = 0; k < NUM_SRC; k++)
          e.rdy[k] = qif.dispatch_src_rdy_i[k] | woke(e.src[k*ADDR_W +: ADDR_W]);
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic disp(input logic v, input logic [OPCODE_W-1:0] op, input logic [ADDR_W-1:0] opd,
                      input logic [ADDR_W-1:0] s0, input logic [ADDR_W-1:0] s1,
                      input logic [NUM_SRC-1:0] rdy);
    qif.dispatch_valid_i   = v;
    qif.dispatch_opcode_i  = op;
    qif.dispatch_opd_i     = opd;
    qif.dispatch_src_i     = {s1, s0};
    qif.dispatch_src_rdy_i = rdy;
  endtask

  task automatic wake(input logic [NUM_WAKE-1:0] v, input logic [ADDR_W-1:0] a0,
                      input logic [ADDR_W-1:0] a1);
    qif.wake_valid_i = v;
    qif.wake_addr_i  = {a1, a0};
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dispatch_ready"}, 32'(qif.dispatch_ready_o), 32'd1);
    chk({tag, "_issue_valid"}, 32'(qif.issue_valid_o), 32'd0);
    chk({tag, "_count"}, 32'(qif.count_o), 32'd0);
    chk({tag, "_empty"}, 32'(qif.empty_o), 32'd1);
    chk({tag, "_issue_opcode"}, 32'(qif.issue_opcode_o), 32'd0);
    chk({tag, "_issue_opd"}, 32'(qif.issue_opd_o), 32'd0);
    chk({tag, "_issue_src"}, 32'(qif.issue_src_o), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    disp(1'b0, '0, '0, '0, '0, '0);
    wake('0, '0, '0);
    qif.issue_ready_i = 1'b0;
    qif.flush_i       = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs("reset");

    // Ready instruction into empty queue, then issue it
    disp(1'b1, 5'd3, 6'd10, 6'd4, 6'd5, 2'b11);
    tick();
    disp(1'b0, '0, '0, '0, '0, '0);
    chk("t1_issue_valid", 32'(qif.issue_valid_o), 32'd1);
    chk("t1_issue_opd", 32'(qif.issue_opd_o), 32'd10);
    qif.issue_ready_i = 1'b1;
    tick();
    chk("t1_count_after", 32'(qif.count_o), 32'd0);
    chk("t1_empty_after", 32'(qif.empty_o), 32'd1);
    tick();

    // Operands arrive by wakeup on two channels at different times
    disp(1'b1, 5'd1, 6'd11, 6'd4, 6'd5, 2'b00);
    tick();
    disp(1'b0, '0, '0, '0, '0, '0);
    wake(2'b01, 6'd4, 6'd0);
    tick();
    wake('0, '0, '0);
    tick();
    tick();
    wake(2'b10, 6'd0, 6'd5);
    chk("t2_wait_valid", 32'(qif.issue_valid_o), 32'd0);
    tick();
    wake('0, '0, '0);
    chk("t2_woken_valid", 32'(qif.issue_valid_o), 32'd1);
    tick();
    tick();

    // Wakeup in the dispatch cycle is captured
    disp(1'b1, 5'd2, 6'd12, 6'd7, 6'd8, 2'b01);
    wake(2'b01, 6'd8, 6'd0);
    tick();
    disp(1'b0, '0, '0, '0, '0, '0);
    wake('0, '0, '0);
    chk("t3_same_cycle_valid", 32'(qif.issue_valid_o), 32'd1);
    tick();
    tick();

    // Fill, then dispatch and issue together across pointer wrap
    qif.issue_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(1'b1, 5'(i), 6'(20 + i), 6'd1, 6'd2, 2'b11);
      tick();
    end
    disp(1'b1, 5'd9, 6'd40, 6'd1, 6'd2, 2'b11);
    chk("t4_full_ready", 32'(qif.dispatch_ready_o), 32'd0);
    chk("t4_full_count", 32'(qif.count_o), 32'd4);
    qif.issue_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      disp(1'b1, 5'(i + 10), 6'(30 + i), 6'(i), 6'(i + 1), 2'b11);
      tick();
    end
    disp(1'b0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 8 && mq.size() > 0; i++) tick();
    chk("t4_drained", 32'(qif.empty_o), 32'd1);

    // Head blocks a ready younger entry until its operand arrives
    qif.issue_ready_i = 1'b0;
    disp(1'b1, 5'd4, 6'd50, 6'd9, 6'd3, 2'b10);
    tick();
    disp(1'b1, 5'd5, 6'd51, 6'd1, 6'd2, 2'b11);
    tick();
    disp(1'b0, '0, '0, '0, '0, '0);
    qif.issue_ready_i = 1'b1;
    tick();
    tick();
    chk("t5_blocked", 32'(qif.issue_valid_o), 32'd0);
    wake(2'b10, 6'd0, 6'd9);
    tick();
    wake('0, '0, '0);
    chk("t5_head_opd", 32'(qif.issue_opd_o), 32'd50);
    tick();
    chk("t5_next_valid", 32'(qif.issue_valid_o), 32'd1);
    chk("t5_next_opd", 32'(qif.issue_opd_o), 32'd51);
    tick();

    // Flush with three entries and a dispatch in the same cycle
    qif.issue_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(1'b1, 5'(i), 6'(60 + i), 6'd1, 6'd2, 2'b11);
      tick();
    end
    disp(1'b1, 5'd7, 6'd63, 6'd1, 6'd2, 2'b11);
    qif.flush_i = 1'b1;
    tick();
    qif.flush_i = 1'b0;
    disp(1'b0, '0, '0, '0, '0, '0);
    chk("t6_flush_count", 32'(qif.count_o), 32'd0);
    chk("t6_flush_empty", 32'(qif.empty_o), 32'd1);
    chk("t6_flush_valid", 32'(qif.issue_valid_o), 32'd0);
    tick();

    // Randomised traffic with a narrow tag space so wakeups collide often
    for (int i = 0; i < 400; i++) begin
      disp(1'($urandom_range(0, 1)), 5'($urandom), 6'($urandom),
           6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 2'($urandom));
      wake(2'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
      qif.issue_ready_i = 1'($urandom_range(0, 1));
      qif.flush_i       = ($urandom_range(0, 39) == 0);
      tick();
    end
    qif.flush_i = 1'b0;
    wake('0, '0, '0);

    // Asynchronous reset with live entries, checked before any clock edge
    qif.issue_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(1'b1, 5'(i), 6'(i), 6'd1, 6'd2, 2'b11);
      tick();
    end
    disp(1'b0, '0, '0, '0, '0, '0);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("async_reset");
    mq.delete();
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eu_wakeup_iqueue.md
Name: eu_wakeup_iqueue

Overview:
- Next-generation execution-unit instruction queue: parametrised circular buffer holding dispatched instructions until all their source operands are present.
- Each entry tracks NUM_SRC operand ready bits, set by NUM_WAKE interconnect wakeup broadcasts.
- Issues strictly in order from the head to the ALU/cache pair, using a valid/ready handshake.
- Adds operand-readiness gating, multi-channel wakeup, flush and occupancy reporting, none of which the first-generation queue provides.

Parameters:
- LOG2_DEPTH, 2, log2 of entry count (depth 4 by default).
- NUM_SRC, 2, source operands per instruction.
- NUM_WAKE, 2, number of wakeup broadcast channels.
- ADDR_W, 6, operand/destination address (tag) width.
- OPCODE_W, 5, opcode width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dispatch_valid_i  in  1  dispatch request.
- dispatch_ready_o  out  1  queue can accept; equals !full.
- dispatch_opcode_i  in  OPCODE_W  opcode.
- dispatch_opd_i  in  ADDR_W  destination address.
- dispatch_src_i  in  NUM_SRC*ADDR_W  source addresses; src k occupies bits [k*ADDR_W +: ADDR_W].
- dispatch_src_rdy_i  in  NUM_SRC  source already present at dispatch time.
- wake_valid_i  in  NUM_WAKE  wakeup strobe per channel.
- wake_addr_i  in  NUM_WAKE*ADDR_W  address being written into the operand cache, per channel.
- issue_valid_o  out  1  head entry valid and all its sources ready.
- issue_ready_i  in  1  ALU accepts the instruction.
- issue_opcode_o  out  OPCODE_W  head opcode.
- issue_opd_o  out  ADDR_W  head destination.
- issue_src_o  out  NUM_SRC*ADDR_W  head source addresses.
- flush_i  in  1  synchronous discard of all entries.
- count_o  out  LOG2_DEPTH+1  occupancy, 0..2^LOG2_DEPTH.
- empty_o  out  1  count_o==0.

Behaviour:
- Reset (asynchronous): write pointer, read pointer and count are 0; all valid and ready bits are 0. Outputs after reset: dispatch_ready_o=1, issue_valid_o=0, count_o=0, empty_o=1, issue_* data outputs=0.
- Pointers are LOG2_DEPTH bits wide and wrap modulo depth. Count is maintained separately; full means count==2^LOG2_DEPTH.
- Dispatch happens on dispatch_valid_i && dispatch_ready_o. It writes the entry at the write pointer and advances the pointer.
- Ready bit k at dispatch = dispatch_src_rdy_i[k] OR (any j: wake_valid_i[j] && wake_addr_i[j]==src k). This same-cycle wakeup is captured, never lost.
- Wakeup: every cycle, each valid entry's not-ready source whose address equals any valid wake address sets its ready bit.
  - Ready bits are only ever set, never cleared, while the entry lives.
  - Matching uses the full ADDR_W.
  - Multiple channels hitting the same source is harmless.
- issue_valid_o and issue_* are driven from registered state only: head valid and all NUM_SRC head ready bits set. Wakeup does not bypass combinationally to issue.
  - Latency: a ready instruction dispatched into an empty queue shows issue_valid_o=1 the next cycle.
  - A wakeup at cycle t makes the head issuable at t+1.
- Issue fires on issue_valid_o && issue_ready_i. The head is invalidated, the read pointer advances, and the next entry is presented the following cycle.
  - No issue can occur while the head is waiting, even if younger entries are ready (in-order issue).
- issue_* data outputs are held stable while issue_valid_o=1 and issue_ready_i=0.
- Simultaneous dispatch and issue: count is unchanged and both pointers advance.
  - When full, dispatch_ready_o=0 even if an issue fires that cycle; there is no pass-through.
- Empty: issue_valid_o=0 and issue_ready_i is ignored.
- flush_i has priority over dispatch, issue and wakeup. Next cycle the queue is in the reset state: count 0, pointers 0, all entries invalid. A dispatch in the flush cycle is dropped.
- count_o and empty_o are registered and consistent with the pointers every cycle.

Decomposition:
- Shared package pkg_dtypes additions:
  - type_wiq_entry struct: valid, opcode[OPCODE_W], opd[ADDR_W], src[NUM_SRC][ADDR_W], src_rdy[NUM_SRC].
  - Constant EU_LOG2_WIQUEUE_DEPTH for the design_parameters default.
- One sub-module: eu_wakeup_match. Combinational; compares NUM_SRC source addresses against NUM_WAKE wake channels and returns a NUM_SRC hit vector.
  - Instantiated once per entry plus once for the dispatch path.

Test Plan:
- Dispatch {opcode 3, opd 10, src 4/5, rdy 2'b11} into an empty queue -> issue_valid_o=1 next cycle with opd 10; issue_ready_i=1 -> count_o returns 0 and empty_o=1.
- Dispatch src 4/5, rdy 2'b00 -> issue_valid_o stays 0. Wake addr 4 on channel 0 at t, addr 5 on channel 1 at t+3 -> issue_valid_o=1 at t+4.
- Same-cycle wake: dispatch src 7/8, rdy 2'b01, while wake_addr 8 is valid -> issuable next cycle.
- Fill 4 entries, hold issue_ready_i=0 -> dispatch_ready_o=0, count_o=4. Then dispatch and issue together for 10 cycles -> pointers wrap, order is preserved, and dispatch_ready_o recovers only once count_o<4.
- Head waiting on src 9 while entry 1 is fully ready -> no issue until wake 9; then head, then entry 1, on consecutive cycles.
- Flush with 3 entries plus a concurrent dispatch -> next cycle count_o=0, empty_o=1, issue_valid_o=0. Also assert reset mid-stream -> all outputs return to reset values immediately, with no clock edge required.
